// File: rtl/ocp_pkg.sv
// ----------------------------------------------------------------------------
// ocp_pkg
// Shared OCP encodings for the burst master: MCmd, SResp and MBurstSeq codes,
// the master FSM state enum, and a small response classification helper.
// ----------------------------------------------------------------------------
package ocp_pkg;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'b000,
        MCMD_WR   = 3'b001,
        MCMD_RD   = 3'b010
    } mcmd_e;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'b00,
        SRESP_DVA  = 2'b01,
        SRESP_FAIL = 2'b10,
        SRESP_ERR  = 2'b11
    } sresp_e;

    localparam logic [2:0] MBURSTSEQ_INCR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WDATA = 2'b10,
        ST_RRESP = 2'b11
    } state_e;

    // A response beat is faulty when the slave reports FAIL or ERR.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SRESP_FAIL) || (resp == SRESP_ERR);
    endfunction

endpackage

// File: rtl/ocp_burst_master_if.sv
// ----------------------------------------------------------------------------
// ocp_burst_master_if
// OCP bus between the burst master and an OCP slave.
//   master modport: drives request (MCmd/MAddr/MBurst*/MReqLast), write data
//                   (MData/MDataValid/MDataLast) and MRespAccept.
//   slave modport : drives SCmdAccept, SDataAccept, SResp, SData, SRespLast.
// ----------------------------------------------------------------------------
interface ocp_burst_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8
);
    logic [2:0]         MCmd;
    logic [ADDR_W-1:0]  MAddr;
    logic [BURST_W-1:0] MBurstLength;
    logic               MBurstPrecise;
    logic [2:0]         MBurstSeq;
    logic               MReqLast;
    logic [DATA_W-1:0]  MData;
    logic               MDataValid;
    logic               MDataLast;
    logic               MRespAccept;
    logic               SCmdAccept;
    logic               SDataAccept;
    logic [1:0]         SResp;
    logic [DATA_W-1:0]  SData;
    logic               SRespLast;

    modport master (
        output MCmd, MAddr, MBurstLength, MBurstPrecise, MBurstSeq, MReqLast,
        output MData, MDataValid, MDataLast, MRespAccept,
        input  SCmdAccept, SDataAccept, SResp, SData, SRespLast
    );

    modport slave (
        input  MCmd, MAddr, MBurstLength, MBurstPrecise, MBurstSeq, MReqLast,
        input  MData, MDataValid, MDataLast, MRespAccept,
        output SCmdAccept, SDataAccept, SResp, SData, SRespLast
    );
endinterface

// File: rtl/ocp_timeout_ctr.sv
// ----------------------------------------------------------------------------
// ocp_timeout_ctr
// No-progress watchdog for the burst master.
//   Clk, reset  : clock, synchronous active-high reset
//   en_i        : clock enable (low holds the count)
//   active_i    : master is busy (not idle)
//   progress_i  : a beat transferred this cycle
//   expire_o    : this is the TIMEOUT-th consecutive no-progress cycle
// ----------------------------------------------------------------------------
module ocp_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic Clk,
    input  logic reset,
    input  logic en_i,
    input  logic active_i,
    input  logic progress_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count reaching LIMIT means TIMEOUT stalled cycles including this one.
    assign expire_o = active_i && !progress_i && (cnt_q == LIMIT);

    // Next count: restart on idle, progress or expiry, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = cnt_q;
        end else if (!active_i || progress_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ocp_burst_master.sv
// ----------------------------------------------------------------------------
// ocp_burst_master
// Converts a bridge request (direction, address, beat count) into one precise
// INCR OCP burst. Writes are posted; reads are streamed to the bridge.
// Ports:
//   Clk, reset, EnableClk   clock, sync active-high reset, OCP clock enable
//   req_*                   bridge request handshake and descriptor
//   wr_*                    write beat stream from the bridge
//   rd_*                    read beat stream to the bridge
//   done/rsp_err/timeout    completion pulse, sticky error, timeout flag
//   ocp                     OCP bus (master modport)
// Build option: define OCP_RESP_TIMEOUT_EN to add the no-progress watchdog
// (limit TIMEOUT cycles); otherwise the master waits indefinitely.
// ----------------------------------------------------------------------------
module ocp_burst_master
    import ocp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               EnableClk,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BURST_W-1:0] req_len,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_last,
    input  logic               rd_ready,
    output logic               done,
    output logic               rsp_err,
    output logic               timeout,
    ocp_burst_master_if.master ocp
);
    state_e             state_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] cnt_q;
    logic               done_q;
    logic               rsp_err_q;
    logic               timeout_q;
    logic [2:0]         mcmd_q;
    logic               mreqlast_q;

    logic last_beat_s;
    logic wr_xfer_s;
    logic rd_xfer_s;
    logic expire_s;

    assign last_beat_s = (cnt_q == (len_q - BURST_W'(1)));
    assign wr_xfer_s   = (state_q == ST_WDATA) && wr_valid && ocp.SDataAccept;
    assign rd_xfer_s   = (state_q == ST_RRESP) && (ocp.SResp != SRESP_NULL) && rd_ready;

`ifdef OCP_RESP_TIMEOUT_EN
    ocp_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .Clk        (Clk),
        .reset      (reset),
        .en_i       (EnableClk),
        .active_i   (state_q != ST_IDLE),
        .progress_i (wr_xfer_s || rd_xfer_s),
        .expire_o   (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    assign ocp.MCmd          = mcmd_q;
    assign ocp.MAddr         = addr_q;
    assign ocp.MBurstLength  = len_q;
    assign ocp.MBurstPrecise = 1'b1;
    assign ocp.MBurstSeq     = MBURSTSEQ_INCR;
    assign ocp.MReqLast      = mreqlast_q;
    assign done              = done_q;
    assign rsp_err           = rsp_err_q;
    assign timeout           = timeout_q;

    // Beat-level pass-through handshakes, live only in their data state.
    always_comb begin
        req_ready       = 1'b0;
        wr_ready        = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
        rd_last         = 1'b0;
        ocp.MData       = '0;
        ocp.MDataValid  = 1'b0;
        ocp.MDataLast   = 1'b0;
        ocp.MRespAccept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_WDATA: begin
                ocp.MData      = wr_data;
                ocp.MDataValid = wr_valid;
                ocp.MDataLast  = last_beat_s;
                wr_ready       = ocp.SDataAccept;
            end
            ST_RRESP: begin
                ocp.MRespAccept = rd_ready;
                rd_valid        = (ocp.SResp != SRESP_NULL);
                rd_data         = ocp.SData;
                rd_last         = last_beat_s;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Burst FSM with registered OCP request and status outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= BURST_W'(1);
            cnt_q      <= '0;
            done_q     <= 1'b0;
            rsp_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            mcmd_q     <= MCMD_IDLE;
            mreqlast_q <= 1'b0;
        end else if (EnableClk) begin
            done_q <= 1'b0;
            if (expire_s) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                done_q     <= 1'b1;
                rsp_err_q  <= 1'b1;
                timeout_q  <= 1'b1;
                mcmd_q     <= MCMD_IDLE;
                mreqlast_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_valid) begin
                            write_q    <= req_write;
                            addr_q     <= req_addr;
                            // A zero beat count still moves one beat.
                            len_q      <= (req_len == '0) ? BURST_W'(1) : req_len;
                            cnt_q      <= '0;
                            rsp_err_q  <= 1'b0;
                            timeout_q  <= 1'b0;
                            mcmd_q     <= req_write ? MCMD_WR : MCMD_RD;
                            mreqlast_q <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (ocp.SCmdAccept) begin
                            mcmd_q     <= MCMD_IDLE;
                            mreqlast_q <= 1'b0;
                            state_q    <= write_q ? ST_WDATA : ST_RRESP;
                        end
                    end
                    ST_WDATA: begin
                        if (wr_xfer_s) begin
                            if (last_beat_s) begin
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                cnt_q <= cnt_q + BURST_W'(1);
                            end
                        end
                    end
                    ST_RRESP: begin
                        if (rd_xfer_s) begin
                            // Error is sticky; the burst still runs to its last beat.
                            if (resp_is_err(ocp.SResp) || (ocp.SRespLast != last_beat_s)) begin
                                rsp_err_q <= 1'b1;
                            end
                            if (last_beat_s) begin
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                cnt_q <= cnt_q + BURST_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ocp_burst_master.sv
// ----------------------------------------------------------------------------
// tb_ocp_burst_master
// Scoreboard bench: the stimulus process issues bursts and pushes the expected
// command, beats and completion status into queues; a negedge monitor pops and
// compares whenever the DUT presents a transfer or completion.
// ----------------------------------------------------------------------------
module tb_ocp_burst_master;

    logic        Clk = 1'b0;
    logic        reset, EnableClk;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
    logic        done, rsp_err, timeout;

    ocp_burst_master_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(8)) bus();

    ocp_burst_master #(.ADDR_W(32), .DATA_W(32), .BURST_W(8), .TIMEOUT(8)) dut (
        .Clk(Clk), .reset(reset), .EnableClk(EnableClk),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .rsp_err(rsp_err), .timeout(timeout),
        .ocp(bus)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [2:0] cmd; logic [31:0] addr; logic [7:0] len; int hold; } cmd_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic err; logic tmo; } done_t;

    cmd_t  cmd_q[$];
    beat_t wq[$];
    beat_t rq[$];
    done_t dq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, expected none", name);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int    hold_cnt   = 0;
    logic  exp_sticky = 1'b0;
    cmd_t  m_c;
    beat_t m_b;
    done_t m_d;

    always @(negedge Clk) begin
        if (reset) begin
            hold_cnt   = 0;
            exp_sticky = 1'b0;
        end else if (EnableClk) begin
            if (done) begin
                if (dq.size() == 0) fail_now("unexpected_done");
                else begin
                    m_d = dq.pop_front();
                    chk("done_rsp_err", {63'd0, rsp_err}, {63'd0, m_d.err});
                    chk("done_timeout", {63'd0, timeout}, {63'd0, m_d.tmo});
                    exp_sticky = m_d.err;
                end
            end
            if (req_valid && req_ready) chk("sticky_rsp_err", {63'd0, rsp_err}, {63'd0, exp_sticky});
            if (bus.MCmd != 3'b000) begin
                hold_cnt++;
                chk("no_wdata_in_req", {63'd0, bus.MDataValid}, 64'd0);
                if (bus.SCmdAccept) begin
                    if (cmd_q.size() == 0) fail_now("unexpected_cmd");
                    else begin
                        m_c = cmd_q.pop_front();
                        chk("mcmd", {61'd0, bus.MCmd}, {61'd0, m_c.cmd});
                        chk("maddr", {32'd0, bus.MAddr}, {32'd0, m_c.addr});
                        chk("mburstlength", {56'd0, bus.MBurstLength}, {56'd0, m_c.len});
                        chk("mreqlast", {63'd0, bus.MReqLast}, 64'd1);
                        chk("mburstprecise", {63'd0, bus.MBurstPrecise}, 64'd1);
                        chk("mburstseq", {61'd0, bus.MBurstSeq}, 64'd0);
                        chk("mcmd_hold_cycles", 64'(hold_cnt), 64'(m_c.hold));
                    end
                    hold_cnt = 0;
                end
            end else begin
                hold_cnt = 0;
                chk("mreqlast_idle", {63'd0, bus.MReqLast}, 64'd0);
            end
            if (bus.MDataValid && bus.SDataAccept) begin
                chk("wr_ready", {63'd0, wr_ready}, 64'd1);
                if (wq.size() == 0) fail_now("unexpected_wbeat");
                else begin
                    m_b = wq.pop_front();
                    chk("mdata", {32'd0, bus.MData}, {32'd0, m_b.data});
                    chk("mdatalast", {63'd0, bus.MDataLast}, {63'd0, m_b.last});
                end
            end
            if (rd_valid && rd_ready) begin
                chk("mrespaccept", {63'd0, bus.MRespAccept}, 64'd1);
                if (rq.size() == 0) fail_now("unexpected_rbeat");
                else begin
                    m_b = rq.pop_front();
                    chk("rd_data", {32'd0, rd_data}, {32'd0, m_b.data});
                    chk("rd_last", {63'd0, rd_last}, {63'd0, m_b.last});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // wr: direction; rnd: random stalls; err_beat/bad_last_beat: read faults;
    // pause_beat: 5-cycle EnableClk gap; reset_beat: reset while that write beat is offered.
    task automatic run_txn(input logic wr, input int len_in, input int cmd_delay, input bit rnd,
                           input int err_beat, input int bad_last_beat, input int pause_beat,
                           input int reset_beat);
        int          len;
        int          k;
        int          idle;
        int          guard;
        bit          acc;
        bit          aborted;
        bit          paused;
        bit          v;
        bit          a;
        logic        exp_err;
        logic [31:0] addr;
        logic [31:0] data[$];
        len     = (len_in == 0) ? 1 : len_in;
        addr    = $urandom;
        exp_err = 1'b0;
        aborted = 1'b0;
        paused  = 1'b0;
        for (int i = 0; i < len; i++) data.push_back($urandom);
        cmd_q.push_back('{wr ? 3'b001 : 3'b010, addr, len[7:0], cmd_delay + 1});
        for (int i = 0; i < len; i++) begin
            if (reset_beat < 0 || i < reset_beat) begin
                if (wr) wq.push_back('{data[i], (i == len - 1)});
                else    rq.push_back('{data[i], (i == len - 1)});
            end
            if (!wr && (i == err_beat || i == bad_last_beat)) exp_err = 1'b1;
        end
        if (reset_beat < 0) dq.push_back('{exp_err, 1'b0});

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len_in[7:0];
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = req_ready;
            step();
        end
        req_valid = 1'b0;
        if (!acc) fail_now("req_accept_timeout");

        // Offer write data during the command phase; it must not appear on OCP.
        wr_valid = wr; wr_data = data[0]; bus.SDataAccept = 1'b1;
        for (int t = 0; t < cmd_delay; t++) step();
        bus.SCmdAccept = 1'b1;
        step();
        bus.SCmdAccept = 1'b0; wr_valid = 1'b0; bus.SDataAccept = 1'b0;

        k = 0; idle = 0; guard = 0;
        while (k < len && guard < 300 && !aborted) begin
            guard++;
            v = !rnd || (idle >= 3) || ($urandom_range(0, 3) != 0);
            a = !rnd || (idle >= 3) || ($urandom_range(0, 3) != 0);
            if (wr) begin
                wr_data = data[k];
                if (k == reset_beat) begin
                    reset = 1'b1; wr_valid = 1'b1; bus.SDataAccept = 1'b1;
                    step();
                    reset = 1'b0; wr_valid = 1'b0; bus.SDataAccept = 1'b0;
                    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
                    chk("rst_mcmd", {61'd0, bus.MCmd}, 64'd0);
                    chk("rst_done", {63'd0, done}, 64'd0);
                    chk("rst_mdatavalid", {63'd0, bus.MDataValid}, 64'd0);
                    aborted = 1'b1;
                end else begin
                    wr_valid = v; bus.SDataAccept = a;
                    step();
                    if (v && a) begin k++; idle = 0; end else idle++;
                end
            end else begin
                bus.SData     = data[k];
                bus.SRespLast = (k == len - 1) ^ (k == bad_last_beat);
                if (k == pause_beat && !paused) begin
                    // Transfer-looking inputs while disabled must not move the burst.
                    paused = 1'b1; EnableClk = 1'b0; bus.SResp = 2'b01; rd_ready = 1'b1;
                    repeat (5) step();
                    EnableClk = 1'b1;
                end
                bus.SResp = v ? ((k == err_beat) ? ((k % 2 == 0) ? 2'b11 : 2'b10) : 2'b01) : 2'b00;
                rd_ready  = a;
                step();
                if (v && a) begin k++; idle = 0; end else idle++;
            end
        end
        wr_valid = 1'b0; bus.SDataAccept = 1'b0; bus.SResp = 2'b00; rd_ready = 1'b0;
        bus.SRespLast = 1'b0;
        if (!aborted && k < len) begin
            fail_now("burst_stall");
            reset = 1'b1; step(); reset = 1'b0;
        end
        step(); step();
    endtask

    int r_w, r_len, r_eb, r_bl, r_pb;

    initial begin
        reset = 1'b1; EnableClk = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        bus.SCmdAccept = 1'b0; bus.SDataAccept = 1'b0; bus.SResp = 2'b00;
        bus.SData = '0; bus.SRespLast = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_mcmd", {61'd0, bus.MCmd}, 64'd0);
        chk("reset_maddr", {32'd0, bus.MAddr}, 64'd0);
        chk("reset_mburstlength", {56'd0, bus.MBurstLength}, 64'd1);
        chk("reset_mburstprecise", {63'd0, bus.MBurstPrecise}, 64'd1);
        chk("reset_mburstseq", {61'd0, bus.MBurstSeq}, 64'd0);
        chk("reset_flags", {61'd0, done, rsp_err, timeout}, 64'd0);
        step();

        run_txn(1'b1, 4, 1, 1'b0, -1, -1, -1, -1);   // write len 4, full acceptance
        run_txn(1'b0, 3, 2, 1'b1, -1, -1, -1, -1);   // read len 3, toggling rd_ready
        run_txn(1'b0, 2, 0, 1'b1,  0, -1, -1, -1);   // read with ERR on beat 1
        run_txn(1'b0, 2, 1, 1'b1, -1, -1, -1, -1);   // clean read: error cleared on accept
        run_txn(1'b1, 4, 0, 1'b0, -1, -1, -1,  1);   // reset during write beat 2
        run_txn(1'b0, 5, 1, 1'b1, -1, -1,  2, -1);   // EnableClk gap mid-read
        run_txn(1'b1, 0, 0, 1'b1, -1, -1, -1, -1);   // zero length acts as one beat
        run_txn(1'b0, 3, 0, 1'b1, -1,  1, -1, -1);   // SRespLast disagrees on beat 2

`ifdef OCP_RESP_TIMEOUT_EN
        dq.push_back('{1'b1, 1'b1});
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; req_len = 8'd4;
        step();
        req_valid = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 7) begin
                chk("tmo_busy_at_7", {63'd0, req_ready}, 64'd0);
                chk("tmo_flag_at_7", {63'd0, timeout}, 64'd0);
            end
        end
        chk("tmo_idle", {63'd0, req_ready}, 64'd1);
        chk("tmo_flag", {63'd0, timeout}, 64'd1);
        chk("tmo_rsp_err", {63'd0, rsp_err}, 64'd1);
        chk("tmo_done", {63'd0, done}, 64'd1);
        chk("tmo_mcmd", {61'd0, bus.MCmd}, 64'd0);
        step(); step();
`else
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; req_len = 8'd4;
        step();
        req_valid = 1'b0;
        repeat (30) step();
        chk("wait_busy", {63'd0, req_ready}, 64'd0);
        chk("wait_no_timeout", {63'd0, timeout}, 64'd0);
        chk("wait_mcmd_rd", {61'd0, bus.MCmd}, 64'd2);
        reset = 1'b1; step(); reset = 1'b0;
        step();
`endif

        for (int n = 0; n < 25; n++) begin
            r_w   = $urandom_range(0, 1);
            r_len = $urandom_range(0, 6);
            r_eb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            r_bl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
            r_pb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            if (r_w != 0) begin
                r_eb = -1; r_bl = -1; r_pb = -1;
            end
            run_txn(r_w[0], r_len, $urandom_range(0, 3), 1'b1, r_eb, r_bl, r_pb, -1);
        end

        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ocp_burst_master.md
OCP_BURST_MASTER -- requirements
Module: ocp_burst_master

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set address width.
REQ-002 Parameter DATA_W, default 32, SHALL set data width.
REQ-003 Parameter BURST_W, default 8, SHALL set burst-length width.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the no-progress cycle limit.
REQ-005 Clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 EnableClk  in  1  OCP clock enable; low holds all state.
REQ-008 req_valid/req_ready  in/out  1/1  bridge request handshake.
REQ-009 req_write, req_addr, req_len  in  1/ADDR_W/BURST_W  direction, start address, beat count.
REQ-010 wr_data/wr_valid/wr_ready  in/in/out  DATA_W/1/1  write beat stream.
REQ-011 rd_data/rd_valid/rd_last/rd_ready  out/out/out/in  DATA_W/1/1/1  read beat stream.
REQ-012 done, rsp_err, timeout  out  1  completion pulse, sticky error, timeout flag.
REQ-013 MCmd, MAddr, MBurstLength  out  3/ADDR_W/BURST_W  OCP request.
REQ-014 MBurstPrecise, MBurstSeq, MReqLast  out  1/3/1  burst qualifiers.
REQ-015 MData, MDataValid, MDataLast  out  DATA_W/1/1  OCP datahandshake.
REQ-016 MRespAccept  out  1; SCmdAccept, SDataAccept, SRespLast  in  1; SResp  in  2; SData  in  DATA_W.

Function
REQ-017 FSM SHALL have states IDLE, REQ, WDATA, RRESP; advance only when EnableClk=1.
REQ-018 IDLE: req_ready=1; on req_valid, latch write/addr/len, clear rsp_err and timeout, go REQ; req_len=0 SHALL be treated as 1.
REQ-019 REQ: MCmd=WR(001) or RD(010), MAddr=latched, MBurstLength=len, MBurstPrecise=1, MBurstSeq=INCR(000), MReqLast=1; hold until SCmdAccept=1, then WDATA (write) or RRESP (read).
REQ-020 Outside REQ, MCmd SHALL be IDLE(000), MReqLast=0.
REQ-021 WDATA: MData=wr_data, MDataValid=wr_valid, wr_ready=SDataAccept, all combinational; a beat transfers when wr_valid & SDataAccept.
REQ-022 Beat counter SHALL count transfers from 0; MDataLast=1 when count==len-1; last transfer -> IDLE with done=1 for one cycle.
REQ-023 RRESP: MRespAccept=rd_ready; beat transfers when SResp!=NULL & rd_ready; rd_valid=SResp!=NULL, rd_data=SData, rd_last=(count==len-1).
REQ-024 SResp FAIL(10) or ERR(11) on any transferred beat SHALL set rsp_err; SRespLast disagreeing with rd_last SHALL set rsp_err.
REQ-025 Last read beat -> IDLE, done pulse one cycle; burst continues after error until last beat.
REQ-026 Write data is never presented before SCmdAccept; writes are posted (no response awaited).
REQ-027 Counter width BURST_W; address never incremented by master (slave computes INCR).

Reset
REQ-028 reset SHALL take priority over EnableClk and all other inputs.
REQ-029 Reset values: state IDLE, counters 0, done/rsp_err/timeout 0, MCmd IDLE, MAddr 0, MBurstLength 1, MBurstPrecise 1, MBurstSeq 000.
REQ-030 reset mid-burst SHALL abort to IDLE in one cycle without done pulse.

Configuration
REQ-031 Macro OCP_RESP_TIMEOUT_EN defined: counter increments each enabled cycle in REQ/WDATA/RRESP without a transfer, clears on transfer; at TIMEOUT go IDLE, set timeout=1 and rsp_err=1, pulse done.
REQ-032 OCP_RESP_TIMEOUT_EN undefined: no counter, timeout tied 0, FSM waits indefinitely.

Structure
REQ-033 Package ocp_pkg SHALL hold MCmd, SResp, MBurstSeq encodings and the state enum.
REQ-034 Timeout counter SHALL be sub-module ocp_timeout_ctr, instantiated only under OCP_RESP_TIMEOUT_EN.

Verification
REQ-035 Write len=4, SCmdAccept after 2 cycles, SDataAccept always 1 -> MCmd=WR 2 cycles, 4 beats, MDataLast on beat 4, done 1 cycle.
REQ-036 Read len=3, SResp=DVA with rd_ready toggling -> 3 beats in order, rd_last on beat 3, rsp_err=0.
REQ-037 Read len=2, beat 1 SResp=ERR -> both beats delivered, rsp_err=1 until next request accepted.
REQ-038 reset during WDATA beat 2 -> next cycle IDLE, MCmd=000, no done.
REQ-039 OCP_RESP_TIMEOUT_EN, TIMEOUT=8, SCmdAccept stuck 0 -> after 8 cycles IDLE, timeout=1, done pulse.
REQ-040 EnableClk=0 for 5 cycles mid-read -> state and count frozen, burst completes correctly after.
